// File: rtl/uart_mm_sequencer.sv
// -----------------------------------------------------------------------------
// uart_mm_sequencer
//   Frame sequencer for the UART-fed matrix multiplier. It loads N*N operand
//   bytes into matrix A, then N*N into matrix B. It then pulses the multiplier
//   start and waits for done. Finally it streams every result word out MSB
//   byte first, in address order.
//
// Ports
//   clk, reset        : system clock, asynchronous active-high reset
//   rx_data/rx_ready  : received byte and its valid level (rising edge = byte)
//   mem_we/sel/addr/wdata : operand memory write port (sel 0 = A, 1 = B)
//   mm_start/mm_done  : multiplier start pulse / completion (level or pulse)
//   res_addr/res_data : result memory read port, 1-cycle read latency
//   tx_data/tx_start/tx_busy : UART transmitter handshake
//   busy              : low only when idle at the start of a frame
//   frame_done        : pulse after the last result byte has been sent
//   rx_overrun        : pulse when a byte arrives outside the load phases
// -----------------------------------------------------------------------------
module uart_mm_sequencer #(
   parameter int N      = 10,
   parameter int RES_W  = 24,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mm_start,
   input  logic              mm_done,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [RES_W-1:0]  res_data,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              busy,
   output logic              frame_done,
   output logic              rx_overrun
);

   localparam int unsigned NBYTES = RES_W / 8;
   localparam int unsigned BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);
   localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NBYTES - 1);

   localparam logic [3:0] S_LOAD_A  = 4'd0;
   localparam logic [3:0] S_LOAD_B  = 4'd1;
   localparam logic [3:0] S_START   = 4'd2;
   localparam logic [3:0] S_WAIT_MM = 4'd3;
   localparam logic [3:0] S_RD      = 4'd4;
   localparam logic [3:0] S_RD_WAIT = 4'd5;
   localparam logic [3:0] S_SEND    = 4'd6;
   localparam logic [3:0] S_TX_ACK  = 4'd7;
   localparam logic [3:0] S_TX_WAIT = 4'd8;

   logic [3:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [BI_W-1:0]   r_byte_idx;
   logic [RES_W-1:0]  r_shift;
   logic              r_rx_q;
   logic              r_rx_armed;

   logic              w_byte_evt;
   logic              w_loading;

   // r_rx_armed stays low until rx_ready has been seen low after reset, so a
   // level already high at reset release is not mistaken for a new byte.
   assign w_byte_evt = rx_ready & ~r_rx_q & r_rx_armed;
   assign w_loading  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign busy       = !((r_state == S_LOAD_A) && (r_cnt == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_LOAD_A;
         r_cnt      <= '0;
         r_byte_idx <= '0;
         r_shift    <= '0;
         r_rx_q     <= 1'b0;
         r_rx_armed <= 1'b0;
         mem_we     <= 1'b0;
         mem_sel    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mm_start   <= 1'b0;
         res_addr   <= '0;
         tx_data    <= '0;
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         r_rx_q <= rx_ready;
         if (!rx_ready) begin
            r_rx_armed <= 1'b1;
         end

         mem_we     <= 1'b0;
         mm_start   <= 1'b0;
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         rx_overrun <= w_byte_evt & ~w_loading;

         case (r_state)
            S_LOAD_A, S_LOAD_B: begin
               if (w_byte_evt) begin
                  mem_we    <= 1'b1;
                  mem_sel   <= (r_state == S_LOAD_B);
                  mem_addr  <= r_cnt;
                  mem_wdata <= rx_data;
                  if (r_cnt == LAST_ADDR) begin
                     r_cnt   <= '0;
                     r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_START;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            S_START: begin
               mm_start <= 1'b1;
               r_state  <= S_WAIT_MM;
            end

            // res_addr is launched on the transition into RD so it is already
            // valid during RD; the registered read data is then present in
            // RD_WAIT, where it is captured.
            S_WAIT_MM: begin
               if (mm_done) begin
                  r_cnt    <= '0;
                  res_addr <= '0;
                  r_state  <= S_RD;
               end
            end

            S_RD: begin
               res_addr <= r_cnt;
               r_state  <= S_RD_WAIT;
            end

            S_RD_WAIT: begin
               r_shift    <= res_data;
               r_byte_idx <= '0;
               r_state    <= S_SEND;
            end

            S_SEND: begin
               if (!tx_busy) begin
                  tx_data  <= r_shift[RES_W-1 -: 8];
                  tx_start <= 1'b1;
                  r_shift  <= r_shift << 8;
                  r_state  <= S_TX_ACK;
               end
            end

            S_TX_ACK: begin
               if (tx_busy) begin
                  r_state <= S_TX_WAIT;
               end
            end

            S_TX_WAIT: begin
               if (!tx_busy) begin
                  if (r_byte_idx != LAST_BYTE) begin
                     r_byte_idx <= r_byte_idx + 1'b1;
                     r_state    <= S_SEND;
                  end else if (r_cnt != LAST_ADDR) begin
                     r_cnt    <= r_cnt + 1'b1;
                     res_addr <= r_cnt + 1'b1;
                     r_state  <= S_RD;
                  end else begin
                     frame_done <= 1'b1;
                     r_cnt      <= '0;
                     r_state    <= S_LOAD_A;
                  end
               end
            end

            default: begin
               r_state <= S_LOAD_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mm_sequencer.sv
module tb_uart_mm_sequencer;

   localparam int N      = 2;
   localparam int RES_W  = 24;
   localparam int ADDR_W = 4;
   localparam int NW     = N * N;
   localparam int NB     = RES_W / 8;
   localparam int NTX    = NW * NB;
   localparam int NOPS   = 2 * NW;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rx_data = '0;
   logic              rx_ready = 1'b0;
   logic              mem_we, mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mm_start;
   logic              mm_done;
   logic [ADDR_W-1:0] res_addr;
   logic [RES_W-1:0]  res_data;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              busy, frame_done, rx_overrun;

   uart_mm_sequencer #(.N(N), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mm_start(mm_start), .mm_done(mm_done), .res_addr(res_addr), .res_data(res_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
      .frame_done(frame_done), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- environment models ----------------
   logic [RES_W-1:0] res_mem [NW];
   int unsigned tx_len = 1, done_dly = 1, done_hold = 1;
   int unsigned dcnt, hcnt, tcnt;
   logic txb, bp_hold = 1'b0;

   assign tx_busy = txb | bp_hold;

   always @(posedge clk)
      res_data <= (int'(res_addr) < NW) ? res_mem[res_addr[1:0]] : '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt <= 0; hcnt <= 0; mm_done <= 1'b0;
      end else if (mm_start) begin
         dcnt <= done_dly;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) begin mm_done <= 1'b1; hcnt <= done_hold; end
      end else if (hcnt != 0) begin
         hcnt <= hcnt - 1;
         if (hcnt == 1) mm_done <= 1'b0;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         txb <= 1'b0; tcnt <= 0;
      end else if (tx_start) begin
         txb <= 1'b1; tcnt <= tx_len;
      end else if (tcnt != 0) begin
         tcnt <= tcnt - 1;
         if (tcnt == 1) txb <= 1'b0;
      end
   end

   // ---------------- monitor ----------------
   logic [12:0] wr_q [$];
   logic [7:0]  tx_q [$];
   int n_start, n_fd, n_ovr, n_viol, start_cyc, last_we_cyc;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) begin
            wr_q.push_back({mem_sel, mem_addr, mem_wdata});
            last_we_cyc = cyc;
         end
         if (mm_start) begin n_start++; start_cyc = cyc; end
         if (tx_start) begin
            tx_q.push_back(tx_data);
            if (prev_busy) n_viol++;
         end
         if (frame_done) n_fd++;
         if (rx_overrun) n_ovr++;
      end
      prev_busy = tx_busy;
   end

   // ---------------- checking helpers ----------------
   int n_chk = 0, n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {33'b0, mem_we, mem_sel, mem_addr, mem_wdata, mm_start, res_addr,
              tx_data, tx_start, busy, frame_done, rx_overrun};
   endfunction

   task automatic clear_mon();
      wr_q.delete(); tx_q.delete();
      n_start = 0; n_fd = 0; n_ovr = 0; n_viol = 0; start_cyc = 0; last_we_cyc = 0;
   endtask

   // Called and returns at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int unsigned hold);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (hold) @(posedge clk);
      #1 rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Reference: each word leaves as NB bytes, most significant first, words in
   // address order. Stream byte k lands in element NTX-1-k.
   function automatic logic [NTX-1:0][7:0] model_tx(input logic [NW-1:0][RES_W-1:0] w);
      logic [NTX-1:0][7:0] e;
      logic [RES_W-1:0] word;
      e = '0;
      for (int a = 0; a < NW; a++) begin
         word = w[a];
         for (int k = 0; k < NB; k++)
            e[NTX-1-(a*NB+k)] = 8'(word >> (8*(NB-1-k)));
      end
      return e;
   endfunction

   function automatic logic [NW-1:0][RES_W-1:0] words_from(input logic [RES_W-1:0] base);
      logic [NW-1:0][RES_W-1:0] w;
      for (int a = 0; a < NW; a++) w[a] = base + RES_W'(a);
      return w;
   endfunction

   // ops: stream byte j is ops[NOPS-1-j]; exp_tx: stream byte k is exp_tx[NTX-1-k].
   task automatic run_frame(input string tag, input logic [NOPS-1:0][7:0] ops,
                            input logic [NW-1:0][RES_W-1:0] words,
                            input logic [NTX-1:0][7:0] exp_tx,
                            input int unsigned hold, input int unsigned tlen,
                            input int unsigned bp, input int unsigned dly,
                            input int unsigned dhold, input bit ovr);
      int t;
      logic [12:0] ew;
      clear_mon();
      for (int a = 0; a < NW; a++) res_mem[a] = words[a];
      tx_len = tlen; done_dly = dly; done_hold = dhold;
      if (bp != 0) bp_hold = 1'b1;
      for (int j = 0; j < NOPS; j++) send_byte(ops[NOPS-1-j], hold);
      if (ovr) begin
         repeat (3) @(posedge clk);
         #1 send_byte(8'hEE, 2);
      end
      if (bp != 0) begin
         repeat (bp) @(posedge clk);
         @(negedge clk);
         check({tag, ".bp_no_tx"}, 64'(tx_q.size()), 64'd0);
         @(posedge clk);
         #1 bp_hold = 1'b0;
      end
      t = 0;
      while (n_fd == 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check({tag, ".wr_count"}, 64'(wr_q.size()), 64'(NOPS));
      for (int j = 0; j < NOPS; j++) begin
         ew = {(j >= NW) ? 1'b1 : 1'b0, 4'(j % NW), ops[NOPS-1-j]};
         if (j < wr_q.size()) check($sformatf("%s.wr%0d", tag, j), 64'(wr_q[j]), 64'(ew));
      end
      check({tag, ".tx_count"}, 64'(tx_q.size()), 64'(NTX));
      for (int k = 0; k < NTX; k++)
         if (k < tx_q.size())
            check($sformatf("%s.tx%0d", tag, k), 64'(tx_q[k]), 64'(exp_tx[NTX-1-k]));
      check({tag, ".mm_start_count"}, 64'(n_start), 64'd1);
      check({tag, ".mm_start_lat"}, 64'(start_cyc - last_we_cyc), 64'd1);
      check({tag, ".frame_done_count"}, 64'(n_fd), 64'd1);
      check({tag, ".overrun_count"}, 64'(n_ovr), ovr ? 64'd1 : 64'd0);
      check({tag, ".tx_start_while_busy"}, 64'(n_viol), 64'd0);
      check({tag, ".idle_busy"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [NOPS-1:0][7:0] ops;
      logic [RES_W-1:0]     base;
      logic [NTX-1:0][7:0]  exp_tx;
      int unsigned          hold;
      int unsigned          tlen;
      int unsigned          bp;
      int unsigned          dly;
      int unsigned          dhold;
   } vec_t;

   vec_t tbl [3];

   initial begin
      logic [NOPS-1:0][7:0] rops;
      logic [NW-1:0][RES_W-1:0] rw;
      bit ovr;

      tbl[0] = '{ops: 64'h0102030405060708, base: 24'h0A0B0C,
                 exp_tx: 96'h0A0B0C_0A0B0D_0A0B0E_0A0B0F,
                 hold: 50, tlen: 3, bp: 0, dly: 4, dhold: 1};
      tbl[1] = '{ops: 64'hFF00807F01FE55AA, base: 24'hFFFFFE,
                 exp_tx: 96'hFFFFFE_FFFFFF_000000_000001,
                 hold: 1, tlen: 2, bp: 1000, dly: 2, dhold: 1};
      tbl[2] = '{ops: 64'h1122334455667788, base: 24'h123456,
                 exp_tx: 96'h123456_123457_123458_123459,
                 hold: 5, tlen: 5, bp: 0, dly: 1, dhold: 4};
      for (int a = 0; a < NW; a++) res_mem[a] = '0;
      clear_mon();

      // Reset with rx_ready already high; release must not count as a byte.
      rx_ready = 1'b1;
      rx_data  = 8'h77;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs(), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rx_high_at_release_no_write", 64'(wr_q.size()), 64'd0);
      rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Byte event to write strobe latency and strobe width.
      rx_data  = 8'h5A;
      rx_ready = 1'b1;
      @(negedge clk);
      check("we_before_edge", 64'(mem_we), 64'd0);
      @(negedge clk);
      check("we_after_1cyc", 64'({mem_we, mem_sel, mem_addr, mem_wdata}),
            64'({1'b1, 1'b0, 4'd0, 8'h5A}));
      @(negedge clk);
      check("we_one_cycle", 64'(mem_we), 64'd0);
      @(posedge clk);
      #1 rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_byte(8'h21, 3);
      send_byte(8'h22, 3);
      @(negedge clk);
      check("busy_mid_load", 64'(busy), 64'd1);

      // Mid-frame reset after 3 A bytes.
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("midreset_outputs", outs(), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++)
         run_frame($sformatf("vec%0d", i), tbl[i].ops, words_from(tbl[i].base),
                   tbl[i].exp_tx, tbl[i].hold, tbl[i].tlen, tbl[i].bp,
                   tbl[i].dly, tbl[i].dhold, 1'b0);

      // Byte arriving while waiting for the multiplier.
      rops = 64'hDEADBEEF01234567;
      rw   = words_from(24'hABCDEF);
      run_frame("overrun", rops, rw, model_tx(rw), 4, 2, 0, 100, 3, 1'b1);

      // Randomized frames against the reference model.
      for (int r = 0; r < 12; r++) begin
         for (int j = 0; j < NOPS; j++) rops[j] = 8'($urandom);
         for (int a = 0; a < NW; a++) rw[a] = RES_W'($urandom);
         ovr = ($urandom_range(0, 3) == 0);
         run_frame($sformatf("rnd%0d", r), rops, rw, model_tx(rw),
                   $urandom_range(1, 20), $urandom_range(1, 8), 0,
                   ovr ? 100 : $urandom_range(1, 30), $urandom_range(1, 6), ovr);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_mm_sequencer.md
# uart_mm_sequencer

Top-level sequencer for the UART-fed matrix multiplier. It consumes bytes from the UART receiver and writes N×N operand matrix A, then matrix B, into the operand memories. It then pulses the multiplier start and waits for done. Finally it reads every result word and streams it out through the UART transmitter, most-significant byte first. It sits between `uart_rx`/`uart_tx` and the pipelined multiplier core.

## Interface
Parameters:
- `N`, 10, matrix dimension
- `RES_W`, 24, result word width; must be a multiple of 8
- `ADDR_W`, 7, address width; must satisfy 2^ADDR_W ≥ N*N

Ports:
- `clk` in 1: system clock; single clock domain
- `reset` in 1: asynchronous, active-high reset
- `rx_data` in 8: received byte from the UART receiver
- `rx_ready` in 1: receiver byte-valid level; may stay high for many cycles per byte
- `mem_we` out 1: operand memory write strobe
- `mem_sel` out 1: 0 = matrix A, 1 = matrix B
- `mem_addr` out ADDR_W: linear address, row*N+col
- `mem_wdata` out 8: operand byte
- `mm_start` out 1: one-cycle start pulse to the multiplier
- `mm_done` in 1: multiplier finished; level or pulse
- `res_addr` out ADDR_W: result memory read address
- `res_data` in RES_W: result word; read latency is 1 cycle
- `tx_data` out 8: byte to transmit
- `tx_start` out 1: one-cycle transmit request
- `tx_busy` in 1: transmitter busy
- `busy` out 1: high in every state except LOAD_A with cnt==0
- `frame_done` out 1: one-cycle pulse after the last result byte has been sent
- `rx_overrun` out 1: one-cycle pulse when a byte arrives outside LOAD_A/LOAD_B

## Operation
Byte detection:
- A byte event is the rising edge of `rx_ready`: `rx_ready`=1 this cycle and registered `rx_ready_q`=0.
- Only byte events are acted on; the level itself is ignored.

States: LOAD_A, LOAD_B, START, WAIT_MM, RD, RD_WAIT, SEND, TX_ACK, TX_WAIT.
- **LOAD_A**
  - On a byte event: next cycle `mem_we`=1, `mem_sel`=0, `mem_addr`=cnt, `mem_wdata`=rx_data.
  - cnt increments. If cnt==N*N-1: cnt←0, go to LOAD_B.
- **LOAD_B**: same as LOAD_A with `mem_sel`=1. After the last write, go to START.
- **START**: `mm_start`=1 for one cycle, then go to WAIT_MM.
- **WAIT_MM**: when `mm_done`=1, cnt←0 and go to RD.
- **RD**: `res_addr`←cnt, go to RD_WAIT.
- **RD_WAIT**: capture `res_data` into a shift register, byte_idx←0, go to SEND.
- **SEND**
  - If `tx_busy`=0: `tx_data`←shift[RES_W-1:RES_W-8], `tx_start`=1 for one cycle, shift left by 8, go to TX_ACK.
  - Otherwise hold in SEND.
- **TX_ACK**: wait for `tx_busy`=1, then go to TX_WAIT.
- **TX_WAIT**: wait for `tx_busy`=0, then:
  - If byte_idx<RES_W/8-1: byte_idx++, go to SEND.
  - Else if cnt<N*N-1: cnt++, go to RD.
  - Else: `frame_done` pulse, cnt←0, go to LOAD_A.

Other rules:
- A byte event in any state other than LOAD_A/LOAD_B is dropped and pulses `rx_overrun` the next cycle.
- cnt and the addresses never exceed N*N-1; there is no wrap beyond the frame.
- Result bytes are unsigned and sent MSB first, RES_W/8 bytes per word, words in address order 0..N*N-1.

## Timing
- Reset values: all outputs 0; state LOAD_A; cnt=0; byte_idx=0; `rx_ready_q`=0.
- Reset asserted mid-frame aborts the frame immediately with no partial `frame_done`; the memory contents are left undefined.
- Byte event to `mem_we` is 1 cycle, and the write strobe lasts exactly 1 cycle.
- Last B write to `mm_start` is 1 cycle (the START state).
- `mm_done` sampled to the first `res_addr` valid is 1 cycle, plus 1 cycle of read latency.
- `tx_start` is asserted only when `tx_busy`=0. The transmitter must raise `tx_busy` within a bounded number of cycles after `tx_start`; TX_ACK waits indefinitely.
- A byte event and `mm_done` in the same cycle: the byte is handled as overrun, and `mm_done` is taken normally.
- `rx_ready` already high at reset release is not a byte event until it falls and rises again.

## Test plan
- **Reset values**: reset pulse -> all outputs 0, `busy`=0. Hold `rx_ready`=1 across reset release -> no write.
- **Load sequence**: N=2, send bytes 1..8 with `rx_ready` high for 50 cycles each.
  - A writes at addresses 0..3 with data 1..4, `mem_sel`=0.
  - B writes at addresses 0..3 with data 5..8, `mem_sel`=1.
  - Exactly 8 `mem_we` pulses, then one `mm_start`.
- **Result streaming**: N=2, RES_W=24, model returns res_data=0x0A0B0C+addr after `mm_done`.
  - `tx_data` sequence is 0A,0B,0C,0A,0B,0D,0A,0B,0E,0A,0B,0F.
  - `frame_done` pulses once after the 12th byte, and the sequencer returns to LOAD_A.
- **Transmitter backpressure**: hold `tx_busy`=1 for 1000 cycles -> no `tx_start` pulse while busy; byte order unchanged.
- **Overrun**: send a byte during WAIT_MM -> `rx_overrun` pulses once, no `mem_we`, cnt unchanged.
- **Mid-frame reset**: reset after 3 A bytes, then send 8 bytes -> writes restart at A address 0.
